// File: rtl/axi_lite_rr_arbiter_if.sv
// AXI4-Lite bus bundle shared by the arbiter's two slave ports and its master port.
//
// Parameters: ADDR_W (address width), DATA_W (data width; strobe is DATA_W/8).
// Modports:
//   master - drives aw/w/ar channels and bready/rready (arbiter -> bridge side)
//   slave  - drives awready/wready/arready and the b/r response channels
interface axi_lite_rr_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// Two-port AXI4-Lite arbiter in front of a single AXI4-Lite slave (the APB bridge).
// One transaction is in flight at a time: it is captured from the granted port,
// replayed on the master port, and the response is returned to the originator.
// Ports are served round-robin; each port alternates read/write when both pend.
//
// Ports:
//   s_axi_clk    - single clock, rising edge
//   s_axi_reset  - synchronous, active-high reset
//   s0_axi       - slave port 0 (from interconnect master 0)
//   s1_axi       - slave port 1 (from interconnect master 1)
//   m_axi        - master port to the bridge; all outputs come from registered state
//   arb_busy     - high whenever the FSM is not idle
//   arb_owner    - port owning the current/last transaction
//
// Optional feature: define ARB_TIMEOUT_EN to abort a downstream wait after
// TIMEOUT_CYCLES cycles and return SLVERR to the owning port.
module axi_lite_rr_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                         s_axi_clk,
    input  logic                         s_axi_reset,
    axi_lite_rr_arbiter_if.slave         s0_axi,
    axi_lite_rr_arbiter_if.slave         s1_axi,
    axi_lite_rr_arbiter_if.master        m_axi,
    output logic                         arb_busy,
    output logic                         arb_owner
);
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic KindRead  = 1'b0;
    localparam logic KindWrite = 1'b1;

    localparam logic [1:0] RespSlvErr = 2'b10;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {StIdle, StMAr, StMAw, StMR, StMB, StSR, StSB} state_e;

    state_e state_q, state_d;

    logic              last_port_q;
    logic [1:0]        last_kind_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        resp_q;
    logic              aw_done_q;
    logic              w_done_q;

    // Request decode: a write needs both address and data valid.
    logic [1:0] req_rd, req_wr, req;
    assign req_rd = {s1_axi.arvalid, s0_axi.arvalid};
    assign req_wr = {s1_axi.awvalid & s1_axi.wvalid, s0_axi.awvalid & s0_axi.wvalid};
    assign req    = req_rd | req_wr;

    logic win;
    logic win_rd;
    always_comb begin
        win = req[1];
        if (req[0] && req[1]) begin
            win = ~last_port_q;
        end
        // With both kinds pending, serve the kind not served last time.
        win_rd = req_rd[win];
        if (req_rd[win] && req_wr[win]) begin
            win_rd = (last_kind_q[win] == KindWrite);
        end
    end

    logic grant_rd, grant_wr;
    assign grant_rd = (state_q == StIdle) && !s_axi_reset && req[win] && win_rd;
    assign grant_wr = (state_q == StIdle) && !s_axi_reset && req[win] && !win_rd;

    logic own_rready, own_bready;
    assign own_rready = owner_q ? s1_axi.rready : s0_axi.rready;
    assign own_bready = owner_q ? s1_axi.bready : s0_axi.bready;

    logic done_r, done_b;
    assign done_r = (state_q == StSR) && own_rready;
    assign done_b = (state_q == StSB) && own_bready;

    logic timeout;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;
    logic            waiting;

    assign waiting = state_q inside {StMAr, StMAw, StMR, StMB};
    assign timeout = waiting && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_ff @(posedge s_axi_clk) begin
        if (s_axi_reset) begin
            cnt_q <= '0;
        end else if (state_d != state_q) begin
            cnt_q <= '0;
        end else if (waiting && !timeout) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Master-side valids/readies depend only on registered state.
    logic aw_pending, w_pending;
    assign aw_pending = (state_q == StMAw) && !aw_done_q && !timeout;
    assign w_pending  = (state_q == StMAw) && !w_done_q && !timeout;

    // State register
    always_ff @(posedge s_axi_clk) begin
        if (s_axi_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (grant_rd) begin
                    state_d = StMAr;
                end else if (grant_wr) begin
                    state_d = StMAw;
                end
            end
            StMAr: begin
                if (timeout) begin
                    state_d = StSR;
                end else if (m_axi.arready) begin
                    state_d = StMR;
                end
            end
            StMAw: begin
                if (timeout) begin
                    state_d = StSB;
                end else if ((aw_done_q || m_axi.awready) && (w_done_q || m_axi.wready)) begin
                    state_d = StMB;
                end
            end
            StMR: begin
                if (timeout || m_axi.rvalid) begin
                    state_d = StSR;
                end
            end
            StMB: begin
                if (timeout || m_axi.bvalid) begin
                    state_d = StSB;
                end
            end
            StSR: begin
                if (own_rready) begin
                    state_d = StIdle;
                end
            end
            StSB: begin
                if (own_bready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        m_axi.arvalid = (state_q == StMAr) && !timeout;
        m_axi.araddr  = addr_q;
        m_axi.awvalid = aw_pending;
        m_axi.awaddr  = addr_q;
        m_axi.wvalid  = w_pending;
        m_axi.wdata   = wdata_q;
        m_axi.wstrb   = wstrb_q;
        m_axi.rready  = (state_q == StMR) && !timeout;
        m_axi.bready  = (state_q == StMB) && !timeout;

        s0_axi.arready = grant_rd && !win;
        s0_axi.awready = grant_wr && !win;
        s0_axi.wready  = grant_wr && !win;
        s0_axi.rvalid  = (state_q == StSR) && !owner_q;
        s0_axi.rdata   = rdata_q;
        s0_axi.rresp   = resp_q;
        s0_axi.bvalid  = (state_q == StSB) && !owner_q;
        s0_axi.bresp   = resp_q;

        s1_axi.arready = grant_rd && win;
        s1_axi.awready = grant_wr && win;
        s1_axi.wready  = grant_wr && win;
        s1_axi.rvalid  = (state_q == StSR) && owner_q;
        s1_axi.rdata   = rdata_q;
        s1_axi.rresp   = resp_q;
        s1_axi.bvalid  = (state_q == StSB) && owner_q;
        s1_axi.bresp   = resp_q;

        arb_busy  = (state_q != StIdle);
        arb_owner = owner_q;
    end

    // Transaction capture and scheduling history
    always_ff @(posedge s_axi_clk) begin
        if (s_axi_reset) begin
            last_port_q <= 1'b1;
            last_kind_q <= {KindWrite, KindWrite};
            owner_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
        end else begin
            if (grant_rd || grant_wr) begin
                owner_q   <= win;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
                if (grant_rd) begin
                    addr_q <= win ? s1_axi.araddr : s0_axi.araddr;
                end else begin
                    addr_q  <= win ? s1_axi.awaddr : s0_axi.awaddr;
                    wdata_q <= win ? s1_axi.wdata : s0_axi.wdata;
                    wstrb_q <= win ? s1_axi.wstrb : s0_axi.wstrb;
                end
            end
            if (aw_pending && m_axi.awready) begin
                aw_done_q <= 1'b1;
            end
            if (w_pending && m_axi.wready) begin
                w_done_q <= 1'b1;
            end
            if ((state_q == StMAr || state_q == StMR) && timeout) begin
                rdata_q <= '0;
                resp_q  <= RespSlvErr;
            end else if (state_q == StMR && m_axi.rvalid) begin
                rdata_q <= m_axi.rdata;
                resp_q  <= m_axi.rresp;
            end
            if ((state_q == StMAw || state_q == StMB) && timeout) begin
                resp_q <= RespSlvErr;
            end else if (state_q == StMB && m_axi.bvalid) begin
                resp_q <= m_axi.bresp;
            end
            if (done_r) begin
                last_port_q          <= owner_q;
                last_kind_q[owner_q] <= KindRead;
            end
            if (done_b) begin
                last_port_q          <= owner_q;
                last_kind_q[owner_q] <= KindWrite;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_rr_arbiter.sv
module tb_axi_lite_rr_arbiter;
    logic clk;
    logic rst;
    logic busy;
    logic owner;
    int   passed;
    int   total;

    axi_lite_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
    axi_lite_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();
    axi_lite_rr_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m_if ();

    axi_lite_rr_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .s_axi_clk  (clk),
        .s_axi_reset(rst),
        .s0_axi     (s0_if),
        .s1_axi     (s1_if),
        .m_axi      (m_if),
        .arb_busy   (busy),
        .arb_owner  (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic idle_inputs();
        s0_if.awaddr = '0; s0_if.awvalid = 0; s0_if.wdata = '0; s0_if.wstrb = '0;
        s0_if.wvalid = 0; s0_if.bready = 0; s0_if.araddr = '0; s0_if.arvalid = 0;
        s0_if.rready = 0;
        s1_if.awaddr = '0; s1_if.awvalid = 0; s1_if.wdata = '0; s1_if.wstrb = '0;
        s1_if.wvalid = 0; s1_if.bready = 0; s1_if.araddr = '0; s1_if.arvalid = 0;
        s1_if.rready = 0;
    endtask

    task automatic bridge(input logic ar, input logic aw, input logic w, input logic rv,
                          input logic bv, input logic [31:0] rd, input logic [1:0] rr,
                          input logic [1:0] br);
        m_if.arready = ar; m_if.awready = aw; m_if.wready = w;
        m_if.rvalid = rv; m_if.bvalid = bv; m_if.rdata = rd;
        m_if.rresp = rr; m_if.bresp = br;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        bridge(0, 0, 0, 0, 0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        bridge(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 2'b11, 2'b11);
        s0_if.arvalid = 1;
        s1_if.awvalid = 1; s1_if.wvalid = 1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else passed++;
        total++; if (owner !== 1'b0) $display("FAIL rst_owner: got %b expected 0", owner); else passed++;
        total++; if (s0_if.arready !== 1'b0) $display("FAIL rst_s0_arready: got %b expected 0", s0_if.arready); else passed++;
        total++; if (s1_if.awready !== 1'b0) $display("FAIL rst_s1_awready: got %b expected 0", s1_if.awready); else passed++;
        total++; if (m_if.arvalid !== 1'b0) $display("FAIL rst_m_arvalid: got %b expected 0", m_if.arvalid); else passed++;
        total++; if ({m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready} !== 4'b0)
            $display("FAIL rst_m_ctrl: got %b expected 0000", {m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready}); else passed++;
        total++; if (m_if.araddr !== 32'h0) $display("FAIL rst_m_araddr: got %h expected 0", m_if.araddr); else passed++;
        total++; if ({s0_if.rvalid, s0_if.bvalid, s0_if.rdata, s0_if.rresp} !== 36'h0)
            $display("FAIL rst_s0_resp: got %h expected 0", {s0_if.rvalid, s0_if.bvalid, s0_if.rdata, s0_if.rresp}); else passed++;
        rst = 1'b0;
        idle_inputs();
        bridge(0, 0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic test_read_latency();
        do_reset();
        bridge(1, 1, 1, 1, 1, 32'hDEAD_BEEF, 2'b00, 2'b00);
        s0_if.araddr = 32'h10; s0_if.arvalid = 1; s0_if.rready = 1;
        #1;
        total++; if (s0_if.arready !== 1'b1) $display("FAIL rd_grant: got %b expected 1", s0_if.arready); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rd_busy_c0: got %b expected 0", busy); else passed++;
        @(negedge clk); s0_if.arvalid = 0; #1;
        total++; if (m_if.arvalid !== 1'b1) $display("FAIL rd_m_arvalid_c1: got %b expected 1", m_if.arvalid); else passed++;
        total++; if (m_if.araddr !== 32'h10) $display("FAIL rd_m_araddr: got %h expected 10", m_if.araddr); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL rd_busy_c1: got %b expected 1", busy); else passed++;
        @(negedge clk); #1;
        total++; if (m_if.rready !== 1'b1) $display("FAIL rd_m_rready_c2: got %b expected 1", m_if.rready); else passed++;
        total++; if (s0_if.rvalid !== 1'b0) $display("FAIL rd_s0_rvalid_c2: got %b expected 0", s0_if.rvalid); else passed++;
        @(negedge clk); #1;
        total++; if (s0_if.rvalid !== 1'b1) $display("FAIL rd_s0_rvalid_c3: got %b expected 1", s0_if.rvalid); else passed++;
        total++; if (s0_if.rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h expected deadbeef", s0_if.rdata); else passed++;
        total++; if (s0_if.rresp !== 2'b00) $display("FAIL rd_rresp: got %b expected 00", s0_if.rresp); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL rd_busy_c3: got %b expected 1", busy); else passed++;
        total++; if (s1_if.rvalid !== 1'b0) $display("FAIL rd_s1_rvalid: got %b expected 0", s1_if.rvalid); else passed++;
        @(negedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL rd_busy_c4: got %b expected 0", busy); else passed++;
        s0_if.rready = 0;
    endtask

    task automatic test_round_robin();
        logic exp_port;
        logic found;
        do_reset();
        bridge(1, 1, 1, 1, 1, 32'h0, 2'b00, 2'b00);
        s0_if.araddr = 32'h100; s1_if.araddr = 32'h200;
        s0_if.arvalid = 1; s1_if.arvalid = 1; s0_if.rready = 1; s1_if.rready = 1;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_port = (i % 2 == 1);
            found = 0;
            for (int c = 0; c < 20; c++) begin
                if (s0_if.arready || s1_if.arready) begin
                    found = 1;
                    break;
                end
                @(negedge clk); #1;
            end
            total++;
            if (!found) $display("FAIL rr_grant_wait round %0d: got no grant, required grant within 20 cycles", i);
            else if ({s1_if.arready, s0_if.arready} !== {exp_port, ~exp_port})
                $display("FAIL rr_grant round %0d: got s1/s0 arready %b%b expected %b%b", i,
                         s1_if.arready, s0_if.arready, exp_port, ~exp_port);
            else passed++;
            @(negedge clk); #1;
            total++; if (owner !== exp_port) $display("FAIL rr_owner round %0d: got %b expected %b", i, owner, exp_port); else passed++;
            total++; if (m_if.araddr !== (exp_port ? 32'h200 : 32'h100))
                $display("FAIL rr_araddr round %0d: got %h expected %h", i, m_if.araddr, exp_port ? 32'h200 : 32'h100); else passed++;
        end
        s0_if.arvalid = 0; s1_if.arvalid = 0;
        repeat (4) @(negedge clk);
        s0_if.rready = 0; s1_if.rready = 0;
    endtask

    task automatic test_kind_alternation();
        logic exp_rd;
        logic found;
        do_reset();
        bridge(1, 1, 1, 1, 1, 32'h0, 2'b00, 2'b00);
        s1_if.araddr = 32'h300; s1_if.awaddr = 32'h304; s1_if.wdata = 32'h1; s1_if.wstrb = 4'hF;
        s1_if.arvalid = 1; s1_if.awvalid = 1; s1_if.wvalid = 1; s1_if.rready = 1; s1_if.bready = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_rd = (i % 2 == 0);
            found = 0;
            for (int c = 0; c < 20; c++) begin
                if (s1_if.arready || s1_if.awready) begin
                    found = 1;
                    break;
                end
                @(negedge clk); #1;
            end
            total++;
            if (!found) $display("FAIL kind_grant_wait %0d: got no grant, required grant within 20 cycles", i);
            else if ({s1_if.arready, s1_if.awready, s1_if.wready} !== {exp_rd, ~exp_rd, ~exp_rd})
                $display("FAIL kind_grant %0d: got ar/aw/w ready %b%b%b expected %b%b%b", i, s1_if.arready,
                         s1_if.awready, s1_if.wready, exp_rd, ~exp_rd, ~exp_rd);
            else passed++;
            @(negedge clk); #1;
            total++; if ({m_if.arvalid, m_if.awvalid} !== {exp_rd, ~exp_rd})
                $display("FAIL kind_m_valid %0d: got ar/aw %b%b expected %b%b", i, m_if.arvalid, m_if.awvalid,
                         exp_rd, ~exp_rd); else passed++;
            total++; if (owner !== 1'b1) $display("FAIL kind_owner %0d: got %b expected 1", i, owner); else passed++;
        end
        s1_if.arvalid = 0; s1_if.awvalid = 0; s1_if.wvalid = 0;
        repeat (4) @(negedge clk);
        s1_if.rready = 0; s1_if.bready = 0;
    endtask

    task automatic test_write_wready_delay();
        do_reset();
        bridge(0, 1, 0, 0, 0, 32'h0, 2'b00, 2'b00);
        s0_if.awaddr = 32'h20; s0_if.wdata = 32'hA5A5_A5A5; s0_if.wstrb = 4'hF;
        s0_if.awvalid = 1; s0_if.wvalid = 1; s0_if.bready = 1;
        #1;
        total++; if ({s0_if.awready, s0_if.wready} !== 2'b11)
            $display("FAIL wr_grant: got aw/w ready %b%b expected 11", s0_if.awready, s0_if.wready); else passed++;
        @(negedge clk); s0_if.awvalid = 0; s0_if.wvalid = 0; #1;
        total++; if ({m_if.awvalid, m_if.wvalid} !== 2'b11)
            $display("FAIL wr_m_valid_c1: got aw/w %b%b expected 11", m_if.awvalid, m_if.wvalid); else passed++;
        total++; if ({m_if.awaddr, m_if.wdata, m_if.wstrb} !== {32'h20, 32'hA5A5_A5A5, 4'hF})
            $display("FAIL wr_m_payload: got %h %h %h expected 20 a5a5a5a5 f", m_if.awaddr, m_if.wdata, m_if.wstrb); else passed++;
        for (int c = 2; c < 5; c++) begin
            @(negedge clk); m_if.awready = 0; #1;
            total++; if ({m_if.awvalid, m_if.wvalid} !== 2'b01)
                $display("FAIL wr_m_valid_c%0d: got aw/w %b%b expected 01", c, m_if.awvalid, m_if.wvalid); else passed++;
        end
        @(negedge clk); m_if.wready = 1; #1;
        total++; if (m_if.wvalid !== 1'b1) $display("FAIL wr_m_wvalid_c5: got %b expected 1", m_if.wvalid); else passed++;
        @(negedge clk); m_if.wready = 0; m_if.bvalid = 1; m_if.bresp = 2'b10; #1;
        total++; if ({m_if.wvalid, m_if.bready} !== 2'b01)
            $display("FAIL wr_m_bready_c6: got wvalid/bready %b%b expected 01", m_if.wvalid, m_if.bready); else passed++;
        @(negedge clk); m_if.bvalid = 0; #1;
        total++; if (s0_if.bvalid !== 1'b1) $display("FAIL wr_s0_bvalid: got %b expected 1", s0_if.bvalid); else passed++;
        total++; if (s0_if.bresp !== 2'b10) $display("FAIL wr_s0_bresp: got %b expected 10", s0_if.bresp); else passed++;
        @(negedge clk); #1;
        total++; if ({busy, s0_if.bvalid} !== 2'b00)
            $display("FAIL wr_done: got busy/bvalid %b%b expected 00", busy, s0_if.bvalid); else passed++;
        s0_if.bready = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bridge(1, 1, 1, 0, 0, 32'h0, 2'b00, 2'b00);
        s1_if.araddr = 32'h40; s1_if.arvalid = 1; s1_if.rready = 1;
        #1;
        total++; if (s1_if.arready !== 1'b1) $display("FAIL mid_grant: got %b expected 1", s1_if.arready); else passed++;
        @(negedge clk); s1_if.arvalid = 0;
        @(negedge clk); #1;
        total++; if ({m_if.rready, owner} !== 2'b11)
            $display("FAIL mid_in_mr: got rready/owner %b%b expected 11", m_if.rready, owner); else passed++;
        rst = 1'b1;
        @(negedge clk); #1;
        total++; if ({m_if.rready, m_if.arvalid, busy, owner, s1_if.rvalid} !== 5'b0)
            $display("FAIL mid_reset_outs: got %b expected 00000",
                     {m_if.rready, m_if.arvalid, busy, owner, s1_if.rvalid}); else passed++;
        rst = 1'b0;
        bridge(1, 1, 1, 1, 1, 32'h1234_5678, 2'b00, 2'b00);
        s0_if.araddr = 32'h44; s0_if.arvalid = 1; s0_if.rready = 1;
        #1;
        total++; if (s0_if.arready !== 1'b1) $display("FAIL mid_new_grant: got %b expected 1", s0_if.arready); else passed++;
        @(negedge clk); s0_if.arvalid = 0;
        @(negedge clk);
        @(negedge clk); #1;
        total++; if ({s0_if.rvalid, s0_if.rdata} !== {1'b1, 32'h1234_5678})
            $display("FAIL mid_new_rdata: got %b %h expected 1 12345678", s0_if.rvalid, s0_if.rdata); else passed++;
        total++; if (s1_if.rvalid !== 1'b0) $display("FAIL mid_no_stale_resp: got %b expected 0", s1_if.rvalid); else passed++;
        @(negedge clk);
        s0_if.rready = 0; s1_if.rready = 0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int   cnt;
        logic seen;
        do_reset();
        bridge(0, 0, 0, 0, 0, 32'hFFFF_FFFF, 2'b00, 2'b00);
        s1_if.araddr = 32'h80; s1_if.arvalid = 1;
        #1;
        total++; if (s1_if.arready !== 1'b1) $display("FAIL to_grant: got %b expected 1", s1_if.arready); else passed++;
        @(negedge clk); s1_if.arvalid = 0;
        cnt = 0; seen = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (s1_if.rvalid) begin
                seen = 1;
                break;
            end
            if (m_if.arvalid) cnt++;
            @(negedge clk);
        end
        total++; if (!seen) $display("FAIL to_rvalid: got no rvalid, required within 40 cycles"); else passed++;
        total++; if (cnt != 8) $display("FAIL to_arvalid_cycles: got %0d expected 8", cnt); else passed++;
        total++; if ({s1_if.rresp, s1_if.rdata} !== {2'b10, 32'h0})
            $display("FAIL to_resp: got %b %h expected 10 00000000", s1_if.rresp, s1_if.rdata); else passed++;
        s1_if.rready = 1;
        @(negedge clk); #1;
        total++; if (busy !== 1'b0) $display("FAIL to_idle: got busy %b expected 0", busy); else passed++;
        s1_if.rready = 0;
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        idle_inputs();
        bridge(0, 0, 0, 0, 0, '0, '0, '0);
        test_reset();
        test_read_latency();
        test_round_robin();
        test_kind_alternation();
        test_write_wready_delay();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axi_lite_rr_arbiter.md
# axi_lite_rr_arbiter

Two-port AXI4-Lite arbiter that shares the single AXI4-Lite slave port of the APB bridge between two AXI4-Lite masters. It accepts one transaction at a time and registers its address, data and strobe. It replays the transaction on the master port, then returns the response to the originating master. Masters are scheduled round-robin, and reads and writes are alternated within each master. It sits between the interconnect masters and the bridge, on the bridge's clock.

## Interface
- ADDR_W, 32, address width, all ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT_CYCLES, 256, downstream wait limit; used only with ARB_TIMEOUT_EN
- s_axi_clk  in  1  single clock, rising edge
- s_axi_reset  in  1  reset; synchronous and active-high
- sN_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write-address channel of slave port N (N=0,1)
- sN_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DATA_W/DATA_W/8/1/1  write-data channel, port N
- sN_axi_bresp/bvalid/bready  out/out/in  2/1/1  write-response channel, port N
- sN_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read-address channel, port N
- sN_axi_rdata/rresp/rvalid/rready  out/out/out/in  DATA_W/2/1/1  read-data channel, port N
- m_axi_aw*/w*/b*/ar*/r*  mirror  same widths  master port to the bridge; directions inverted
- arb_busy  out  1  high in every state except IDLE
- arb_owner  out  1  port that owns the current transaction; holds its last value in IDLE

## Operation
- Request of port N: arvalid_N, or awvalid_N together with wvalid_N. awvalid without wvalid is not a request.
- Port selection: `last_port` register, reset value 1, so port 0 wins first. When both ports request, the port not equal to `last_port` wins. `last_port` updates on completion only.
- Kind selection: each port has a `last_kind` flag, reset value "write", so read goes first. If a port has both read and write pending, it gets the kind opposite to `last_kind`. The flag updates on completion.
- FSM states: IDLE, M_AR, M_AW, M_R, M_B, S_R, S_B.
- IDLE:
  - Grant is combinational.
  - Read grant: winner's arready=1 for the cycle.
  - Write grant: winner's awready=1 and wready=1 in the same cycle.
  - Address, data and strobe are captured.
  - Next state is M_AR or M_AW.
- M_AR: m_axi_arvalid=1 with the captured address. On m_axi_arready, go to M_R.
- M_AW:
  - m_axi_awvalid=1 and m_axi_wvalid=1 on entry.
  - Each valid drops independently after its own ready handshake.
  - When both handshakes are done, go to M_B.
- M_R: m_axi_rready=1. On m_axi_rvalid, capture rdata and rresp, then go to S_R.
- M_B: m_axi_bready=1. On m_axi_bvalid, capture bresp, then go to S_B.
- S_R: owner's rvalid=1 with the captured data and resp. On owner's rready, go to IDLE.
- S_B: owner's bvalid=1 with the captured bresp. On owner's bready, go to IDLE.
- Completion (S_R/S_B handshake) updates `last_port` and the owner's `last_kind`.
- The non-owner port sees all readies and valids at 0 until it is granted.
- Response codes pass through unmodified, except on timeout.

## Timing
- Reset: every valid and ready output is 0, every data and resp output is 0, and:
  - FSM in IDLE
  - arb_busy=0, arb_owner=0
  - `last_port`=1; both `last_kind` flags = write
- Reset mid-transaction discards the transaction; no response is issued.
- Zero-wait read latency, with the slave arready handshake at cycle 0:
  - m_axi_arvalid at cycle 1
  - M_R at cycle 2
  - sN_rvalid at cycle 3
- Zero-wait write: sN_bvalid 3 cycles after the slave aw/w handshake.
- Back-to-back transactions: IDLE lasts 1 cycle minimum between transactions, so the next grant is 1 cycle after the S_R/S_B handshake.
- Simultaneous requests in the same cycle follow the port and kind rules above. Ties are never broken by arrival order.
- m_axi outputs are driven from registers only; there is no combinational path from sN inputs to m_axi outputs.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in M_AR, M_AW, M_R and M_B, and clears on every state change.
  - When the counter reaches TIMEOUT_CYCLES, all m_axi valids and readies drop.
  - The FSM enters S_R (rdata=0, rresp=2'b10) or S_B (bresp=2'b10).
  - Stale downstream responses are not filtered; the system resets the bridge after a timeout.
- Undefined: no counter; the arbiter waits indefinitely.

## Test plan
- Port 0 read of 0x10, bridge zero-wait returning 0xDEADBEEF/OKAY -> s0_rvalid at cycle 3 with rdata=0xDEADBEEF, rresp=0; arb_busy high in cycles 1-3.
- Both ports issue a read in the same cycle after reset, for 3 rounds -> grant order 0,1,0,1,0,1; arb_owner tracks each grant.
- Port 1 holds read and write pending continuously while port 0 is idle -> kinds alternate R,W,R,W, starting with R.
- Write 0xA5A5A5A5, strb 0xF: bridge delays m_axi_wready by 4 cycles after awready, then returns bresp=2'b10 -> m_axi_awvalid drops first, m_axi_wvalid drops later, s0_bresp=2'b10.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, bridge never asserts arready -> s1_rvalid with rresp=2'b10 and rdata=0 after 8 cycles in M_AR, then IDLE.
- Assert s_axi_reset during M_R -> next cycle all outputs at reset values; a new read from port 0 completes normally.
